// File: rtl/clock_divide_controller.sv
// Runtime-programmable clock divider: 50% duty o_clock of 2N i_clock cycles with glitch-free ratio updates.
// Optional period counter output enabled by defining CLKDIV_PERIOD_COUNT_EN.
module clock_divide_controller #(
   parameter int unsigned COUNT_WIDTH         = 16,
   parameter int unsigned DEFAULT_HALF_PERIOD = 5
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_enable,
   input  logic                   i_cfg_valid,
   input  logic [COUNT_WIDTH-1:0] i_cfg_half_period,
   output logic                   o_cfg_ready,
   output logic                   o_cfg_err,
   output logic                   o_clock,
   output logic                   o_tick,
   output logic                   o_running
`ifdef CLKDIV_PERIOD_COUNT_EN
   ,
   output logic [15:0]            o_period_count
`endif
);

   localparam int unsigned PCNT_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0] cnt_next;
   logic [COUNT_WIDTH-1:0] active_n;
   logic [COUNT_WIDTH-1:0] active_n_next;
   logic [COUNT_WIDTH-1:0] pend_n;
   logic [COUNT_WIDTH-1:0] pend_n_next;
   logic                   pend_vld;
   logic                   pend_vld_next;

   logic phase_end_c;
   logic low_end_c;
   logic xfer_c;
   logic cfg_zero_c;

   logic clock_d;
   logic tick_d;
   logic running_d;
   logic ready_d;
   logic err_d;

   assign phase_end_c = (state != S_IDLE) && (cnt == (active_n - COUNT_WIDTH'(1)));
   assign low_end_c   = (state == S_LOW) && phase_end_c;
   assign xfer_c      = i_cfg_valid && o_cfg_ready;
   assign cfg_zero_c  = (i_cfg_half_period == '0);

   // State and datapath registers
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         active_n <= COUNT_WIDTH'(DEFAULT_HALF_PERIOD);
         pend_n   <= '0;
         pend_vld <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         active_n <= active_n_next;
         pend_n   <= pend_n_next;
         pend_vld <= pend_vld_next;
      end
   end

   // Next-state, phase counter and config staging
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      active_n_next = active_n;
      pend_n_next   = pend_n;
      pend_vld_next = pend_vld;

      case (state)
         S_IDLE: begin
            cnt_next = '0;
            if (i_enable) state_next = S_HIGH;
         end
         S_HIGH: begin
            if (phase_end_c) begin
               cnt_next   = '0;
               state_next = S_LOW;
            end else begin
               cnt_next = cnt + COUNT_WIDTH'(1);
            end
         end
         S_LOW: begin
            if (phase_end_c) begin
               cnt_next   = '0;
               state_next = i_enable ? S_HIGH : S_IDLE;
            end else begin
               cnt_next = cnt + COUNT_WIDTH'(1);
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = S_IDLE;
         end
      endcase

      // Pending ratio lands on the period boundary before any same-edge transfer is staged
      if (low_end_c && pend_vld) begin
         active_n_next = pend_n;
         pend_vld_next = 1'b0;
      end
      if (xfer_c && !cfg_zero_c) begin
         if (state == S_IDLE) begin
            active_n_next = i_cfg_half_period;
         end else begin
            pend_n_next   = i_cfg_half_period;
            pend_vld_next = 1'b1;
         end
      end
   end

   // Output decode from the upcoming state so every output is a flop
   always_comb begin
      clock_d   = 1'b0;
      tick_d    = 1'b0;
      running_d = 1'b0;
      ready_d   = 1'b1;
      err_d     = 1'b0;

      clock_d   = (state_next == S_HIGH);
      tick_d    = (state_next == S_HIGH) && (state != S_HIGH);
      running_d = (state_next != S_IDLE);
      ready_d   = !pend_vld_next;
      err_d     = xfer_c && cfg_zero_c;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_clock     <= 1'b0;
         o_tick      <= 1'b0;
         o_running   <= 1'b0;
         o_cfg_ready <= 1'b1;
         o_cfg_err   <= 1'b0;
      end else begin
         o_clock     <= clock_d;
         o_tick      <= tick_d;
         o_running   <= running_d;
         o_cfg_ready <= ready_d;
         o_cfg_err   <= err_d;
      end
   end

`ifdef CLKDIV_PERIOD_COUNT_EN
   // Completed periods, counted at each end of LOW; wraps naturally
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_period_count <= '0;
      end else if (low_end_c) begin
         o_period_count <= o_period_count + PCNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_clock_divide_controller.sv
// Self-checking bench for clock_divide_controller: constant vector table, directed corner
// sequences and randomized traffic against a period-position reference model.
module tb_clock_divide_controller;

   logic        i_clock = 1'b0;
   logic        i_reset_n = 1'b1;
   logic        i_enable = 1'b0;
   logic        i_cfg_valid = 1'b0;
   logic [15:0] i_cfg_half_period = 16'd0;
   logic        o_cfg_ready;
   logic        o_cfg_err;
   logic        o_clock;
   logic        o_tick;
   logic        o_running;
`ifdef CLKDIV_PERIOD_COUNT_EN
   logic [15:0] o_period_count;
`endif

   clock_divide_controller dut (
      .i_clock           (i_clock),
      .i_reset_n         (i_reset_n),
      .i_enable          (i_enable),
      .i_cfg_valid       (i_cfg_valid),
      .i_cfg_half_period (i_cfg_half_period),
      .o_cfg_ready       (o_cfg_ready),
      .o_cfg_err         (o_cfg_err),
      .o_clock           (o_clock),
      .o_tick            (o_tick),
      .o_running         (o_running)
`ifdef CLKDIV_PERIOD_COUNT_EN
      ,
      .o_period_count    (o_period_count)
`endif
   );

   always #5 i_clock = ~i_clock;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: position within a 2N-cycle period
   bit m_run;
   int m_pos;
   int m_n;
   int m_pend;   // 0 = nothing pending (pending values are always nonzero)
   bit m_rdy;
   bit m_err;
   bit m_tick;
   int m_cnt;

   function automatic void model_reset();
      m_run = 0; m_pos = 0; m_n = 5; m_pend = 0;
      m_rdy = 1; m_err = 0; m_tick = 0; m_cnt = 0;
   endfunction

   function automatic void model_edge(input bit en, input bit v, input int d);
      bit xfer;
      bit was_idle;
      xfer     = v && m_rdy;
      was_idle = !m_run;
      m_tick   = 0;
      if (!m_run) begin
         if (en) begin m_run = 1; m_pos = 0; m_tick = 1; end
      end else if (m_pos == 2 * m_n - 1) begin
         if (m_pend != 0) begin m_n = m_pend; m_pend = 0; end
         m_cnt = (m_cnt + 1) % 65536;
         if (en) begin m_pos = 0; m_tick = 1; end
         else m_run = 0;
      end else begin
         m_pos++;
      end
      m_err = xfer && (d == 0);
      if (xfer && d != 0) begin
         if (was_idle) m_n = d;
         else m_pend = d;
      end
      m_rdy = (m_pend == 0);
   endfunction

   function automatic logic [31:0] model_out();
      bit clk;
      clk = m_run && (m_pos < m_n);
      return 32'({m_rdy, m_err, clk, m_tick, m_run});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_out();
      return 32'({o_cfg_ready, o_cfg_err, o_clock, o_tick, o_running});
   endfunction

   task automatic step(input bit en, input bit v, input logic [15:0] d);
      i_enable = en; i_cfg_valid = v; i_cfg_half_period = d;
      @(posedge i_clock);
      model_edge(en, v, int'(d));
      #1;
      check("model_outputs", dut_out(), model_out());
`ifdef CLKDIV_PERIOD_COUNT_EN
      check("model_period_count", 32'(o_period_count), 32'(m_cnt));
`endif
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0; i_enable = 1'b0; i_cfg_valid = 1'b0; i_cfg_half_period = 16'd0;
      #1;
      check("reset_outputs", dut_out(), 32'h10);
`ifdef CLKDIV_PERIOD_COUNT_EN
      check("reset_period_count", 32'(o_period_count), 32'd0);
`endif
      @(posedge i_clock);
      @(posedge i_clock);
      #1;
      i_reset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit          en;
      bit          v;
      logic [15:0] d;
      logic [4:0]  exp;   // {ready, err, clock, tick, running}
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit en, input bit v, input logic [15:0] d, input logic [4:0] exp);
      vec_t r;
      r.en = en; r.v = v; r.d = d; r.exp = exp;
      tbl.push_back(r);
   endfunction

   initial begin
      logic exp_clk[12];
      logic exp_rdy[12];
      int   hi;

      model_reset();
      // Default N=5 run, rejected zero config, then stop requested during HIGH
      add(0, 0, 0, 5'b10000);
      add(1, 0, 0, 5'b10111);
      add(1, 0, 0, 5'b10101);
      add(1, 1, 0, 5'b11101);
      add(1, 0, 0, 5'b10101);
      add(1, 0, 0, 5'b10101);
      for (int i = 0; i < 5; i++) add(1, 0, 0, 5'b10001);
      add(1, 0, 0, 5'b10111);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 5'b10101);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 5'b10001);
      add(0, 0, 0, 5'b10000);
      add(0, 0, 0, 5'b10000);

      #2;
      do_reset();
      foreach (tbl[i]) begin
         i_enable = tbl[i].en; i_cfg_valid = tbl[i].v; i_cfg_half_period = tbl[i].d;
         @(posedge i_clock);
         #1;
         check($sformatf("table_%0d", i), dut_out(), 32'(tbl[i].exp));
      end

      // Ratio change to N=2 requested in the second HIGH cycle
      do_reset();
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 16'd2);
      check("n2_ready_drop", 32'(o_cfg_ready), 32'd0);
      exp_clk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 0);
         check($sformatf("n2_clock_%0d", i), 32'(o_clock), 32'(exp_clk[i]));
         check($sformatf("n2_ready_%0d", i), 32'(o_cfg_ready), 32'(exp_rdy[i]));
      end

      // N=1 loaded while idle: toggle every cycle, ready never drops
      do_reset();
      step(0, 1, 16'd1);
      check("n1_ready_idle", 32'(o_cfg_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0);
         check($sformatf("n1_clock_%0d", i), 32'(o_clock), (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("n1_ready_%0d", i), 32'(o_cfg_ready), 32'd1);
      end

      // Enable dropped during HIGH and restored before LOW ends: no gap
      do_reset();
      step(1, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 0);
      step(1, 0, 0);
      check("reassert_tick", 32'({o_clock, o_tick, o_running}), 32'b111);

      // Reset mid-LOW with a pending ratio: pending discarded, N back to 5
      do_reset();
      step(1, 0, 0);
      step(1, 1, 16'd3);
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      check("pend_before_reset", 32'({o_clock, o_cfg_ready}), 32'b00);
      do_reset();
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (o_clock) hi++;
      end
      check("post_reset_high_len", 32'(hi), 32'd5);
      check("post_reset_ready", 32'(o_cfg_ready), 32'd1);

`ifdef CLKDIV_PERIOD_COUNT_EN
      do_reset();
      for (int i = 0; i < 31; i++) step(1, 0, 0);
      check("period_count_3", 32'(o_period_count), 32'd3);
      do_reset();
`endif

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bit          en;
         bit          v;
         logic [15:0] d;
         int          r;
         if ($urandom_range(0, 599) == 0) do_reset();
         en = ($urandom_range(0, 9) != 0);
         v  = ($urandom_range(0, 3) == 0);
         r  = int'($urandom_range(0, 9));
         if (r == 0) d = 16'd0;
         else if (r <= 3) d = 16'(r);
         else if (r == 9) d = 16'($urandom_range(10, 25));
         else d = 16'($urandom_range(1, 8));
         step(en, v, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
